// File: rtl/lerp_arbiter_if.sv
// Requester, shared-lerp and result-stage signals of lerp_arbiter.
// The master side drives requests and the lerp result; the slave side is the arbiter.
interface lerp_arbiter_if #(
    parameter int NUM_REQ         = 4,
    parameter int INPUT_BITS      = 16,
    parameter int RATIO_FRAC_BITS = 8,
    parameter int ID_BITS         = $clog2(NUM_REQ)
);
    logic [NUM_REQ-1:0]                 req_valid;
    logic [NUM_REQ-1:0]                 req_ready;
    logic [NUM_REQ*INPUT_BITS-1:0]      req_a;
    logic [NUM_REQ*INPUT_BITS-1:0]      req_b;
    logic [NUM_REQ*RATIO_FRAC_BITS-1:0] req_ratio;

    logic [INPUT_BITS-1:0]              lerp_a;
    logic [INPUT_BITS-1:0]              lerp_b;
    logic [RATIO_FRAC_BITS-1:0]         lerp_ratio;
    logic [INPUT_BITS-1:0]              lerp_out;

    logic                               res_valid;
    logic                               res_ready;
    logic [INPUT_BITS-1:0]              res_data;
    logic [ID_BITS-1:0]                 res_id;

    modport master (
        output req_valid, req_a, req_b, req_ratio, lerp_out, res_ready,
        input  req_ready, lerp_a, lerp_b, lerp_ratio, res_valid, res_data, res_id
    );

    modport slave (
        input  req_valid, req_a, req_b, req_ratio, lerp_out, res_ready,
        output req_ready, lerp_a, lerp_b, lerp_ratio, res_valid, res_data, res_id
    );
endinterface

// File: rtl/lerp_arbiter.sv
// Work-conserving round-robin share of one combinational lerp between NUM_REQ
// requesters, with a one-entry registered result stage that supports backpressure.
module lerp_arbiter #(
    parameter int NUM_REQ         = 4,
    parameter int INPUT_BITS      = 16,
    parameter int RATIO_FRAC_BITS = 8,
    parameter int ID_BITS         = $clog2(NUM_REQ)
) (
    input logic           clk,
    input logic           reset,
    lerp_arbiter_if.slave bus
);
    localparam int                 CAND_W    = ID_BITS + 1;
    localparam logic [CAND_W-1:0]  NUM_REQ_C = CAND_W'(NUM_REQ);
    localparam logic [ID_BITS-1:0] LAST_ID   = ID_BITS'(NUM_REQ - 1);

    logic [INPUT_BITS-1:0]      a_arr     [NUM_REQ];
    logic [INPUT_BITS-1:0]      b_arr     [NUM_REQ];
    logic [RATIO_FRAC_BITS-1:0] ratio_arr [NUM_REQ];

    logic [ID_BITS-1:0]    rr_ptr;
    logic [ID_BITS-1:0]    grant_idx;
    logic [CAND_W-1:0]     cand;
    logic                  grant_found;
    logic                  issue_en;
    logic                  handshake;

    logic                  res_valid;
    logic [INPUT_BITS-1:0] res_data;
    logic [ID_BITS-1:0]    res_id;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign a_arr[g]     = bus.req_a[g*INPUT_BITS +: INPUT_BITS];
        assign b_arr[g]     = bus.req_b[g*INPUT_BITS +: INPUT_BITS];
        assign ratio_arr[g] = bus.req_ratio[g*RATIO_FRAC_BITS +: RATIO_FRAC_BITS];
    end

    // Search from rr_ptr upward; the candidate is one bit wider so the wrap
    // subtraction keeps it inside 0..NUM_REQ-1 even when NUM_REQ is not 2^n.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        grant_found = 1'b0;
        grant_idx   = rr_ptr;
        cand        = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = {1'b0, rr_ptr} + CAND_W'(k);
            if (cand >= NUM_REQ_C) begin
                cand = cand - NUM_REQ_C;
            end
            if (!grant_found && bus.req_valid[cand[ID_BITS-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = cand[ID_BITS-1:0];
            end
        end
    end

    assign issue_en  = !res_valid || bus.res_ready;
    assign handshake = grant_found && issue_en && !reset;

    always_comb begin
        bus.req_ready = '0;
        if (handshake) begin
            bus.req_ready[grant_idx] = 1'b1;
        end
    end

    // With no grant grant_idx rests on rr_ptr, so the lerp inputs are never X.
    assign bus.lerp_a     = a_arr[grant_idx];
    assign bus.lerp_b     = b_arr[grant_idx];
    assign bus.lerp_ratio = ratio_arr[grant_idx];

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: the result payload is reset as well so res_data/res_id read 0 after reset, not X.
            res_valid <= 1'b0;
            res_data  <= '0;
            res_id    <= '0;
            rr_ptr    <= '0;
        end else if (handshake) begin
            res_valid <= 1'b1;
            res_data  <= bus.lerp_out;
            res_id    <= grant_idx;
            rr_ptr    <= (grant_idx == LAST_ID) ? '0 : grant_idx + 1'b1;
        end else if (res_valid && bus.res_ready) begin
            res_valid <= 1'b0;
        end
    end

    assign bus.res_valid = res_valid;
    assign bus.res_data  = res_data;
    assign bus.res_id    = res_id;
endmodule

// File: tb/tb_lerp_arbiter.sv
// Self-checking bench for lerp_arbiter: directed scenarios plus randomized traffic
// compared each cycle against a behavioural arbitration/result-stage model.
module tb_lerp_arbiter;
    localparam int N   = 4;
    localparam int IB  = 16;
    localparam int RB  = 8;
    localparam int IDB = 2;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    lerp_arbiter_if #(.NUM_REQ(N), .INPUT_BITS(IB), .RATIO_FRAC_BITS(RB), .ID_BITS(IDB)) bus ();

    lerp_arbiter #(.NUM_REQ(N), .INPUT_BITS(IB), .RATIO_FRAC_BITS(RB), .ID_BITS(IDB)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [N-1:0]  valid_q;
    logic [IB-1:0] a_q [N];
    logic [IB-1:0] b_q [N];
    logic [RB-1:0] r_q [N];
    logic          res_ready_q;

    always_comb begin
        bus.req_valid = valid_q;
        bus.res_ready = res_ready_q;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.req_ratio = '0;
        for (int i = 0; i < N; i++) begin
            bus.req_a[i*IB +: IB]     = a_q[i];
            bus.req_b[i*IB +: IB]     = b_q[i];
            bus.req_ratio[i*RB +: RB] = r_q[i];
        end
    end

    function automatic logic [IB-1:0] lerp_ref(input logic [IB-1:0] a, input logic [IB-1:0] b,
                                               input logic [RB-1:0] r);
        int d;
        int p;
        d = int'(b) - int'(a);
        p = d * int'(r);
        return IB'(int'(a) + (p >>> RB));
    endfunction

    // The shared lerp instance the arbiter feeds.
    assign bus.lerp_out = lerp_ref(bus.lerp_a, bus.lerp_b, bus.lerp_ratio);

    int n_checks = 0;
    int n_err    = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model state.
    int            m_ptr;
    int            m_id;
    logic          m_valid;
    logic [IB-1:0] m_data;
    logic [N-1:0]  last_hs;
    int            wait_cnt [N];

    task automatic new_data(input int i);
        a_q[i] = IB'($urandom);
        b_q[i] = IB'($urandom);
        r_q[i] = RB'($urandom);
    endtask

    // Called at posedge+1 with inputs applied; checks, advances the model, returns at next posedge+1.
    task automatic tick();
        int           exp_idx;
        bit           found;
        bit           issue;
        logic [N-1:0] exp_ready;
        #1;
        found   = 1'b0;
        exp_idx = m_ptr;
        for (int k = 0; k < N; k++) begin
            int idx;
            idx = (m_ptr + k) % N;
            if (!found && valid_q[idx]) begin
                found   = 1'b1;
                exp_idx = idx;
            end
        end
        issue     = !m_valid || res_ready_q;
        exp_ready = '0;
        if (!reset && found && issue) exp_ready[exp_idx] = 1'b1;

        check("req_ready",  32'(bus.req_ready),  32'(exp_ready));
        check("lerp_a",     32'(bus.lerp_a),     32'(a_q[exp_idx]));
        check("lerp_b",     32'(bus.lerp_b),     32'(b_q[exp_idx]));
        check("lerp_ratio", 32'(bus.lerp_ratio), 32'(r_q[exp_idx]));
        check("res_valid",  32'(bus.res_valid),  32'(m_valid));
        check("res_data",   32'(bus.res_data),   32'(m_data));
        check("res_id",     32'(bus.res_id),     32'(m_id));

        last_hs = bus.req_valid & bus.req_ready;

        if (reset) begin
            for (int i = 0; i < N; i++) wait_cnt[i] = 0;
        end else if (exp_ready != '0) begin
            for (int i = 0; i < N; i++) begin
                if (exp_ready[i]) begin
                    check("fair_wait", 32'(wait_cnt[i] < N), 32'd1);
                    wait_cnt[i] = 0;
                end else if (valid_q[i]) begin
                    wait_cnt[i]++;
                end
            end
        end

        if (reset) begin
            m_valid = 1'b0;
            m_data  = '0;
            m_id    = 0;
            m_ptr   = 0;
        end else if (exp_ready != '0) begin
            m_valid = 1'b1;
            m_data  = lerp_ref(a_q[exp_idx], b_q[exp_idx], r_q[exp_idx]);
            m_id    = exp_idx;
            m_ptr   = (exp_idx + 1) % N;
        end else if (m_valid && res_ready_q) begin
            m_valid = 1'b0;
        end

        @(posedge clk);
        #1;
    endtask

    // After a tick: requesters that handshook either present new data or drop valid.
    task automatic refresh(input bit keep);
        for (int i = 0; i < N; i++) begin
            if (last_hs[i]) begin
                if (keep) new_data(i);
                else      valid_q[i] = 1'b0;
            end
        end
    endtask

    task automatic drain();
        int budget;
        budget      = 40;
        res_ready_q = 1'b1;
        while (valid_q != '0 && budget > 0) begin
            tick();
            refresh(1'b0);
            budget--;
        end
        if (valid_q != '0) check("drain_timeout", 32'(valid_q), 32'd0);
        tick();
    endtask

    task automatic run_single(input int idx, input logic [IB-1:0] a, input logic [IB-1:0] b,
                              input logic [RB-1:0] r, input logic [IB-1:0] exp);
        valid_q      = '0;
        valid_q[idx] = 1'b1;
        a_q[idx]     = a;
        b_q[idx]     = b;
        r_q[idx]     = r;
        res_ready_q  = 1'b1;
        tick();
        check("dir_data", 32'(bus.res_data), 32'(exp));
        check("dir_id",   32'(bus.res_id),   32'(idx));
        refresh(1'b0);
        tick();
    endtask

    int served [N];
    int prev_id;
    int cur_id;

    initial begin
        reset       = 1'b1;
        res_ready_q = 1'b1;
        valid_q     = '1;
        for (int i = 0; i < N; i++) begin
            new_data(i);
            wait_cnt[i] = 0;
            served[i]   = 0;
        end
        m_valid = 1'b0;
        m_data  = '0;
        m_id    = 0;
        m_ptr   = 0;
        last_hs = '0;

        @(posedge clk);
        #1;
        repeat (3) tick();
        reset = 1'b0;

        // Round-robin order straight out of reset.
        for (int k = 0; k < 8; k++) begin
            tick();
            check("rr_order", 32'(bus.res_id), 32'(k % N));
            refresh(1'b1);
        end
        drain();

        run_single(2, 16'd100,   16'd0,   8'd128, 16'd50);
        run_single(2, 16'd3,     16'd0,   8'd128, 16'd1);
        run_single(0, 16'd0,     16'd256, 8'd255, 16'd255);
        run_single(1, 16'd500,   16'd500, 8'd200, 16'd500);
        run_single(3, 16'hFFFF,  16'd0,   8'd0,   16'hFFFF);

        // Backpressure, then release: each requester served exactly 3 times in 12 slots.
        valid_q = '1;
        for (int i = 0; i < N; i++) new_data(i);
        tick();
        refresh(1'b1);
        res_ready_q = 1'b0;
        repeat (5) begin
            tick();
            refresh(1'b1);
        end
        res_ready_q = 1'b1;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (bus.res_valid === 1'b1 && bus.res_id < N) served[bus.res_id]++;
            refresh(1'b1);
        end
        for (int i = 0; i < N; i++) check("bp_served", 32'(served[i]), 32'd3);
        drain();

        // Only requesters 1 and 3 valid: ids alternate.
        valid_q = 4'b1010;
        new_data(1);
        new_data(3);
        prev_id = -1;
        for (int k = 0; k < 8; k++) begin
            tick();
            cur_id = int'(bus.res_id);
            if (prev_id < 0) check("alt_first", 32'(cur_id == 1 || cur_id == 3), 32'd1);
            else             check("alt_id", 32'(cur_id), 32'(prev_id == 1 ? 3 : 1));
            prev_id = cur_id;
            refresh(1'b1);
        end
        drain();

        // Reset while a result is held under backpressure.
        valid_q = '1;
        for (int i = 0; i < N; i++) new_data(i);
        res_ready_q = 1'b0;
        tick();
        refresh(1'b1);
        tick();
        check("held_valid", 32'(bus.res_valid), 32'd1);
        reset = 1'b1;
        tick();
        check("rst_valid", 32'(bus.res_valid), 32'd0);
        reset       = 1'b0;
        res_ready_q = 1'b1;
        tick();
        check("post_rst_id", 32'(bus.res_id), 32'd0);
        refresh(1'b1);

        // Randomized traffic with occasional resets.
        for (int k = 0; k < 400; k++) begin
            res_ready_q = ($urandom_range(0, 3) != 0);
            reset       = ($urandom_range(0, 99) == 0);
            for (int i = 0; i < N; i++) begin
                if (!valid_q[i] && $urandom_range(0, 1) == 1) begin
                    valid_q[i] = 1'b1;
                    new_data(i);
                end
            end
            tick();
            refresh(1'b0);
        end
        reset = 1'b0;
        drain();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
